stim_pattern_gen: RTL

//  Synthesizable, parametrised stimulus sequencer for bring-up and self-test of button/switch-driven logic.
//  Per run: pulses a downstream reset, toggles N button lines on a programmable period, flips a switch line,

---
 rtl/stim_pkg.sv | 22 ++
 rtl/stim_lfsr.sv | 29 ++
 rtl/stim_pattern_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus pattern generator.
// Holds the FSM state encoding, the jitter LFSR tap mask and the counter sizing helper.
package stim_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_TOGGLE,
      S_SWITCH,
      S_WAIT
   } state_t;

   // x^8+x^6+x^5+x^4+1 with the register shifting towards bit 7
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam int         JITTER_W  = 3;

   // A counter that has to hold max_val needs $clog2(max_val+1) bits, and always at least one.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 8-bit Fibonacci LFSR that supplies toggle-period jitter.
// The load input reseeds the register so that every run repeats the same sequence.
module stim_lfsr
   import stim_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic                step,
   output logic [JITTER_W-1:0] jitter
);

   logic [7:0] q;
   logic       feedback;

   assign feedback = ^(q & LFSR_TAPS);
   assign jitter   = q[JITTER_W-1:0];

   always_ff @(posedge clock) begin
      if (reset || load) begin
         q <= SEED;
      end else if (step) begin
         q <= {q[6:0], feedback};
      end
   end

endmodule

// File: rtl/stim_pattern_gen.sv
// Stimulus sequencer: reset pulse, button toggling, one switch flip, then an idle wait; single-shot or looping.
// Define STIM_JITTER_EN to stretch each toggle period by 0..7 cycles taken from a reseeded LFSR.
module stim_pattern_gen
   import stim_pkg::*;
#(
   parameter int         CHANNELS      = 4,
   parameter int         TOGGLE_PERIOD = 10,
   parameter int         TOGGLE_COUNT  = 34,
   parameter int         RST_CYCLES    = 2,
   parameter int         IDLE_CYCLES   = 100,
   parameter logic [7:0] LFSR_SEED     = 8'hA5,
   localparam int        CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                continuous,
   input  logic                rr_mode,
   input  logic [CH_W-1:0]     ch_sel,
   output logic                stim_reset,
   output logic [CHANNELS-1:0] button,
   output logic                switch,
   output logic                busy,
   output logic                done
);

`ifdef STIM_JITTER_EN
   localparam int PER_MAX = TOGGLE_PERIOD + (1 << JITTER_W) - 1;
`else
   localparam int PER_MAX = TOGGLE_PERIOD;
`endif
   localparam int PER_W  = cnt_w(PER_MAX);
   localparam int TOG_W  = cnt_w(TOGGLE_COUNT);
   localparam int RST_W  = cnt_w(RST_CYCLES);
   localparam int WAIT_W = cnt_w(IDLE_CYCLES);

   state_t            state;
   logic [RST_W-1:0]  rst_cnt;
   logic [PER_W-1:0]  period_cnt;
   logic [TOG_W-1:0]  toggle_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              rr_q;
   logic [CH_W-1:0]   start_ch;
   logic [CH_W-1:0]   cur_ch;
   logic [CH_W-1:0]   next_ch;
   logic [CH_W-1:0]   sel_clamped;
   logic [PER_W-1:0]  period_last;
   logic              period_end;

   assign sel_clamped = (int'(ch_sel) >= CHANNELS) ? '0 : ch_sel;
   assign next_ch     = (cur_ch == CH_W'(CHANNELS - 1)) ? '0 : cur_ch + 1'b1;
   assign period_end  = (state == S_TOGGLE) && (period_cnt == period_last);

`ifdef STIM_JITTER_EN
   logic [JITTER_W-1:0] jitter;

   // Held in load for the whole S_RST phase, so each run starts from the seed.
   stim_lfsr #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clock (clock),
      .reset (reset),
      .load  (state == S_RST),
      .step  (period_end),
      .jitter(jitter)
   );

   assign period_last = PER_W'(TOGGLE_PERIOD - 1) + PER_W'(jitter);
`else
   logic unused_seed;

   assign unused_seed = ^{LFSR_SEED, LFSR_TAPS};
   assign period_last = PER_W'(TOGGLE_PERIOD - 1);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         stim_reset <= 1'b0;
         button     <= '0;
         switch     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rst_cnt    <= '0;
         period_cnt <= '0;
         toggle_cnt <= '0;
         wait_cnt   <= '0;
         rr_q       <= 1'b0;
         start_ch   <= '0;
         cur_ch     <= '0;
      end else begin
         done <= 1'b0;
         // NOTE: stop is tested ahead of the state case so that it overrides every transition below.
         if (stop && (state != S_IDLE)) begin
            state      <= S_IDLE;
            stim_reset <= 1'b0;
            button     <= '0;
            busy       <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !stop) begin
                     state      <= S_RST;
                     stim_reset <= 1'b1;
                     busy       <= 1'b1;
                     rst_cnt    <= '0;
                     rr_q       <= rr_mode;
                     start_ch   <= rr_mode ? '0 : sel_clamped;
                     cur_ch     <= rr_mode ? '0 : sel_clamped;
                  end
               end
               S_RST: begin
                  if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                     state      <= S_TOGGLE;
                     stim_reset <= 1'b0;
                     period_cnt <= '0;
                     toggle_cnt <= '0;
                  end else begin
                     rst_cnt <= rst_cnt + 1'b1;
                  end
               end
               S_TOGGLE: begin
                  if (period_end) begin
                     period_cnt     <= '0;
                     button[cur_ch] <= ~button[cur_ch];
                     toggle_cnt     <= toggle_cnt + 1'b1;
                     if (rr_q) begin
                        cur_ch <= next_ch;
                     end
                     if (toggle_cnt == TOG_W'(TOGGLE_COUNT - 1)) begin
                        state <= S_SWITCH;
                     end
                  end else begin
                     period_cnt <= period_cnt + 1'b1;
                  end
               end
               S_SWITCH: begin
                  switch   <= ~switch;
                  state    <= S_WAIT;
                  wait_cnt <= '0;
               end
               S_WAIT: begin
                  if (wait_cnt == WAIT_W'(IDLE_CYCLES - 1)) begin
                     if (continuous) begin
                        state      <= S_RST;
                        stim_reset <= 1'b1;
                        rst_cnt    <= '0;
                        cur_ch     <= start_ch;
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
